ab_sensor_conditioner: RTL and testbench
========================================

// Module: ab_sensor_conditioner
//
// PURPOSE
//   Front end for the parking-lot car sensors. It sits between the raw
//   photo-sensor pins (A, B) and the car enter/exit FSM.
//   Per channel it provides:
//   - a 2-FF synchroniser;
//   - a counter-based debouncer;
//   - one-cycle rise/fall strobes.
//   The FSM only ever sees clean, single-clock-domain levels.
//
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000    cycles a synced level must hold before it is accepted (10 ms @ 100 MHz); min 2
//   DB_BITS          20           width of debounce counter; must satisfy 2**DB_BITS > DEBOUNCE_CYCLES
//   STUCK_CYCLES     500_000_000  cycles clean level may stay 1 before stuck flag (5 s @ 100 MHz)
//   STUCK_BITS       29           width of stuck counter; must satisfy 2**STUCK_BITS > STUCK_CYCLES
//
// PORTS
//   clk       in   1  system clock (CLK100MHZ at top level)
//   reset_n   in   1  asynchronous, active-low reset
//   a_raw     in   1  raw sensor A pin; asynchronous, may bounce; 1 = beam blocked
//   b_raw     in   1  raw sensor B pin; same as a_raw
//   a_clean   out  1  debounced A level; drives FSM input A
//   b_clean   out  1  debounced B level; drives FSM input B
//   a_rise    out  1  1-cycle pulse when a_clean goes 0->1
//   a_fall    out  1  1-cycle pulse when a_clean goes 1->0
//   b_rise    out  1  1-cycle pulse when b_clean goes 0->1
//   b_fall    out  1  1-cycle pulse when b_clean goes 1->0
//   stuck     out  2  [1]=B, [0]=A; level stuck-high flag (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset (reset_n=0, async):
//   - sync FFs, debounce counters, stuck counters cleared.
//   - All outputs 0: a_clean, b_clean, all strobes, stuck=2'b00.
// - Synchroniser:
//   - raw -> s1 -> s2 on each clk rising edge.
//   - s2 is the only signal the debouncer reads.
// - Debouncer, per channel, fully independent:
//   - s2 == clean: cnt <= 0.
//   - s2 != clean and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - s2 != clean and cnt == DEBOUNCE_CYCLES-1: clean <= s2, cnt <= 0.
//   - Any return of s2 to clean before acceptance restarts the count from 0.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches clean.
// - Latency:
//   - Raw change first sampled at edge k -> clean updates at edge k+DEBOUNCE_CYCLES+1.
// - Strobes:
//   - Registered; asserted in exactly the cycle clean first shows its new value.
//   - High for one cycle only.
//   - rise and fall of one channel are never high together.
// - Simultaneous events:
//   - A and B may both be accepted on the same edge; both strobes fire together.
//   - No priority between channels.
// - Reset mid-debounce:
//   - Pending count discarded; clean returns to 0.
//   - After release, a raw input held at 1 produces a_rise/b_rise DEBOUNCE_CYCLES+2 edges later.
//   - No strobe on the reset edge itself.
// - Counters saturate by construction (cleared on acceptance); no wrap-around is reachable.
//
// CONFIGURATION
//   Macro: SENSOR_STUCK_DETECT_EN
//   - Defined:
//     - Per-channel stuck counter increments while clean==1; clears whenever clean==0.
//     - When it reaches STUCK_CYCLES-1, stuck[n] <= 1 and the counter holds.
//     - stuck[n] clears on the cycle after clean[n] falls, or on reset.
//   - Undefined:
//     - No stuck counters are synthesised.
//     - stuck is tied to 2'b00; the port is retained so the interface is unchanged.
//
// TESTING  (sim with DEBOUNCE_CYCLES=4, STUCK_CYCLES=16)
//   1. Reset asserted 3 cycles with a_raw=b_raw=1 -> all outputs 0 during reset; after release
//      a_clean=b_clean=1 and a_rise, b_rise each pulse once, 6 edges after release.
//   2. a_raw 0->1 held -> a_clean rises exactly 5 edges after first sampling edge; a_rise=1 for 1 cycle.
//   3. b_raw bounce 1,0,1,0 every 2 cycles then steady 0 from clean=1 -> b_clean stays 1 until
//      4+1 edges after the last bounce; exactly one b_fall; no b_rise.
//   4. a_raw pulse of 3 cycles (< DEBOUNCE_CYCLES) -> a_clean unchanged, no strobes.
//   5. a_raw, b_raw rise on same edge -> a_rise, b_rise asserted in the same cycle.
//   6. SENSOR_STUCK_DETECT_EN defined, a_raw held 1 -> stuck=2'b01 16 cycles after a_clean rises;
//      drop a_raw -> stuck back to 2'b00 one cycle after a_clean falls.
//      Macro undefined -> stuck always 2'b00.
//      Reset asserted mid-count (a_raw=1, cnt=2) -> a_clean=0, and a_rise occurs only after a full
//      re-count following release.

Source files
------------

// File: rtl/ab_sensor_conditioner.sv
// Sensor A/B front end: 2-FF synchroniser, counter debouncer and rise/fall strobes per channel.
// Optional per-channel stuck-high detector enabled by defining SENSOR_STUCK_DETECT_EN.
module ab_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DB_BITS         = 20,
    parameter int unsigned STUCK_CYCLES    = 500_000_000,
    parameter int unsigned STUCK_BITS      = 29
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a_clean,
    output logic       b_clean,
    output logic       a_rise,
    output logic       a_fall,
    output logic       b_rise,
    output logic       b_fall,
    output logic [1:0] stuck
);

    if (DEBOUNCE_CYCLES < 2 || (64'd1 << DB_BITS) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_db_cfg
        $error("ab_sensor_conditioner: DEBOUNCE_CYCLES/DB_BITS out of range");
    end
    if (STUCK_CYCLES < 1 || (64'd1 << STUCK_BITS) <= 64'(STUCK_CYCLES)) begin : g_bad_stuck_cfg
        $error("ab_sensor_conditioner: STUCK_CYCLES/STUCK_BITS out of range");
    end

    localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = channel A, bit 1 = channel B throughout.
    logic [1:0]         raw;
    logic [1:0]         s1_q, s2_q;
    logic [1:0]         clean_q, clean_d;
    logic [1:0]         rise_q, rise_d;
    logic [1:0]         fall_q, fall_d;
    logic [DB_BITS-1:0] db_cnt_q [2];
    logic [DB_BITS-1:0] db_cnt_d [2];

    assign raw = {b_raw, a_raw};

    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            db_cnt_d[ch] = '0;
            if (s2_q[ch] != clean_q[ch]) begin
                if (db_cnt_q[ch] == DB_LAST) begin
                    // Strobes are computed alongside the accepted level so they coincide with it.
                    clean_d[ch] = s2_q[ch];
                    rise_d[ch]  = s2_q[ch];
                    fall_d[ch]  = ~s2_q[ch];
                end else begin
                    db_cnt_d[ch] = db_cnt_q[ch] + DB_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            clean_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            db_cnt_q <= '{default: '0};
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign a_clean = clean_q[0];
    assign b_clean = clean_q[1];
    assign a_rise  = rise_q[0];
    assign b_rise  = rise_q[1];
    assign a_fall  = fall_q[0];
    assign b_fall  = fall_q[1];

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [STUCK_BITS-1:0] STUCK_LAST = STUCK_BITS'(STUCK_CYCLES - 1);

    logic [STUCK_BITS-1:0] stk_cnt_q [2];
    logic [1:0]            stuck_q;

    // Counter holds at its last value once the flag is raised; a low clean level clears both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stk_cnt_q <= '{default: '0};
            stuck_q   <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (!clean_q[ch]) begin
                    stk_cnt_q[ch] <= '0;
                    stuck_q[ch]   <= 1'b0;
                end else if (stk_cnt_q[ch] == STUCK_LAST) begin
                    stuck_q[ch]   <= 1'b1;
                end else begin
                    stk_cnt_q[ch] <= stk_cnt_q[ch] + STUCK_BITS'(1);
                end
            end
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = '0;
`endif

endmodule

// File: tb/tb_ab_sensor_conditioner.sv
// Directed bench for ab_sensor_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=16.
// Stuck expectations follow SENSOR_STUCK_DETECT_EN as built.
module tb_ab_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_raw, b_raw;
    logic       a_clean, b_clean;
    logic       a_rise, a_fall, b_rise, b_fall;
    logic [1:0] stuck;

    int n_tests = 0;
    int n_fail  = 0;
    int n_a_rise = 0, n_a_fall = 0, n_b_rise = 0, n_b_fall = 0;
    int s_a_rise, s_a_fall, s_b_rise, s_b_fall;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [1:0] STK_BOTH = 2'b11;
    localparam logic [1:0] STK_B    = 2'b10;
`else
    localparam logic [1:0] STK_BOTH = 2'b00;
    localparam logic [1:0] STK_B    = 2'b00;
`endif

    ab_sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .DB_BITS        (3),
        .STUCK_CYCLES   (16),
        .STUCK_BITS     (5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a_clean(a_clean),
        .b_clean(b_clean),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall),
        .stuck  (stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_rise) n_a_rise++;
        if (a_fall) n_a_fall++;
        if (b_rise) n_b_rise++;
        if (b_fall) n_b_fall++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_a_rise = n_a_rise; s_a_fall = n_a_fall;
        s_b_rise = n_b_rise; s_b_fall = n_b_fall;
    endtask

    initial begin
        reset_n = 1'b0;
        a_raw   = 1'b1;
        b_raw   = 1'b1;

        // 1: reset with both inputs high, then release
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs", {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, stuck}, 0);
        end
        reset_n = 1'b1;
        snap();
        tick(5);
        check("t1_before", {a_clean, b_clean, a_rise, b_rise}, 4'b0000);
        tick();
        check("t1_edge6", {a_clean, b_clean, a_rise, b_rise}, 4'b1111);
        tick();
        check("t1_strobe_end", {a_rise, b_rise, a_fall, b_fall}, 4'b0000);
        check("t1_rise_cnt", (n_a_rise - s_a_rise) * 16 + (n_b_rise - s_b_rise), 32'h11);

        // 2: a low, then rising edge latency
        a_raw = 1'b0;
        tick(8);
        check("t2_setup", {a_clean, b_clean}, 2'b01);
        a_raw = 1'b1;
        snap();
        tick(5);
        check("t2_before", a_clean, 0);
        tick();
        check("t2_edge", {a_clean, a_rise, a_fall}, 3'b110);
        tick();
        check("t2_strobe_end", a_rise, 0);
        check("t2_rise_cnt", n_a_rise - s_a_rise, 1);

        // 3: b bounces then settles low
        snap();
        for (int i = 0; i < 2; i++) begin
            b_raw = 1'b0;
            tick(2);
            check("t3_bounce_lo", b_clean, 1);
            b_raw = 1'b1;
            tick(2);
            check("t3_bounce_hi", b_clean, 1);
        end
        b_raw = 1'b0;
        tick(5);
        check("t3_before", b_clean, 1);
        tick();
        check("t3_edge", {b_clean, b_fall, b_rise}, 3'b010);
        tick(3);
        check("t3_counts", (n_b_fall - s_b_fall) * 16 + (n_b_rise - s_b_rise), 32'h10);

        // 4: short a glitch is rejected
        snap();
        a_raw = 1'b0;
        tick(3);
        a_raw = 1'b1;
        tick(10);
        check("t4_clean", a_clean, 1);
        check("t4_strobes", (n_a_rise - s_a_rise) + (n_a_fall - s_a_fall), 0);

        // 5: simultaneous rise on both channels
        a_raw = 1'b0;
        tick(8);
        check("t5_setup", {a_clean, b_clean}, 2'b00);
        a_raw = 1'b1;
        b_raw = 1'b1;
        tick(5);
        check("t5_before", {a_clean, b_clean}, 2'b00);
        tick();
        check("t5_edge", {a_clean, b_clean, a_rise, b_rise}, 4'b1111);

        // 6: stuck flag timing and clearing
        tick(15);
        check("t6_stuck_pre", stuck, 2'b00);
        tick();
        check("t6_stuck_set", stuck, STK_BOTH);
        a_raw = 1'b0;
        tick(5);
        check("t6_hold", {a_clean, stuck}, {1'b1, STK_BOTH});
        tick();
        check("t6_fall", {a_clean, a_fall, stuck}, {2'b01, STK_BOTH});
        tick();
        check("t6_clear", stuck, STK_B);

        // 7: reset in the middle of a debounce count
        a_raw = 1'b1;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("t7_async_rst", {a_clean, b_clean, a_rise, a_fall, b_rise, b_fall, stuck}, 0);
        snap();
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check("t7_before", {a_clean, b_clean}, 2'b00);
        check("t7_no_strobe", (n_a_rise - s_a_rise) + (n_b_rise - s_b_rise)
                              + (n_a_fall - s_a_fall) + (n_b_fall - s_b_fall), 0);
        tick();
        check("t7_edge", {a_clean, b_clean, a_rise, b_rise, stuck}, 6'b111100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
